// File: rtl/timer_sequencer_pkg.sv
// timer_sequencer_pkg: shared types and constants for the timer sequencer.
package timer_sequencer_pkg;
    localparam int TMR_W        = 16;
    localparam int WD_SLACK_DEF = 4;

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_RUN, S_GAP, S_DONE} state_t;

    // A zero period would never end a Timer period, so it is driven as 1.
    function automatic logic [TMR_W-1:0] clamp_n(input logic [TMR_W-1:0] v);
        return (v == '0) ? TMR_W'(1) : v;
    endfunction
endpackage

// File: rtl/timer_sequencer_table.sv
// timer_sequencer_table: DEPTH x 16 period table, one write port, one async read port.
module timer_sequencer_table
    import timer_sequencer_pkg::*;
#(
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [TMR_W-1:0]  wdata_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [TMR_W-1:0]  rdata_o
);
    logic [TMR_W-1:0] mem_q [DEPTH];
    logic [TMR_W-1:0] mem_d [DEPTH];

    always_comb begin
        mem_d = mem_q;
        if (we_i) mem_d[waddr_i] = wdata_i;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) mem_q <= '{default: '0};
        else        mem_q <= mem_d;
    end

    assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/timer_sequencer.sv
// timer_sequencer: runs a table of Timer periods back to back for a number of passes,
// pulsing done at the end and flagging a Timer that never ends a period.
module timer_sequencer
    import timer_sequencer_pkg::*;
#(
    parameter int DEPTH    = 8,
    parameter int ADDR_W   = 3,
    parameter int WD_SLACK = WD_SLACK_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cfg_we_i,
    input  logic [ADDR_W-1:0] cfg_addr_i,
    input  logic [TMR_W-1:0]  cfg_n_i,
    input  logic [ADDR_W:0]   seq_len_i,
    input  logic [7:0]        loops_i,
    input  logic              go_i,
    input  logic              abort_i,
    input  logic              tmr_end_i,
    output logic [TMR_W-1:0]  tmr_n_q,
    output logic              tmr_start_q,
    output logic [ADDR_W-1:0] step_idx_q,
    output logic              busy_q,
    output logic              done_q,
    output logic              err_q
);
    localparam logic [ADDR_W:0] LEN_MAX = (ADDR_W+1)'(DEPTH);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] step_idx_d;
    logic [ADDR_W:0]   len_q, len_d;
    logic [7:0]        pass_q, pass_d, loops_q, loops_d;
    logic [16:0]       wd_q, wd_d, wd_cnt, wd_lim;
    logic [TMR_W-1:0]  tmr_n_d, rd_n;
    logic              tmr_start_d, busy_d, done_d, err_d, last_entry, last_pass;

    timer_sequencer_table #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_table (
        .clk     (clk),
        .rst_n   (rst_n),
        .we_i    (cfg_we_i && state_q == S_IDLE),
        .waddr_i (cfg_addr_i),
        .wdata_i (cfg_n_i),
        .raddr_i (step_idx_q),
        .rdata_o (rd_n)
    );

    // wd_cnt is the 1-based count of the current RUN cycle.
    assign wd_cnt     = &wd_q ? wd_q : wd_q + 17'd1;
    assign wd_lim     = {1'b0, tmr_n_q} + 17'(WD_SLACK + 1);
    assign last_entry = {1'b0, step_idx_q} == len_q - (ADDR_W+1)'(1);
    assign last_pass  = pass_q == loops_q - 8'd1;

    always_comb begin
        state_d    = state_q;
        step_idx_d = step_idx_q;
        len_d      = len_q;
        pass_d     = pass_q;
        loops_d    = loops_q;
        wd_d       = wd_q;
        tmr_n_d    = tmr_n_q;
        err_d      = err_q;
        if (abort_i) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: if (go_i && seq_len_i != '0) begin
                    state_d    = S_LOAD;
                    len_d      = (seq_len_i > LEN_MAX) ? LEN_MAX : seq_len_i;
                    loops_d    = (loops_i == 8'd0) ? 8'd1 : loops_i;
                    step_idx_d = '0;
                    pass_d     = 8'd0;
                    err_d      = 1'b0;
                end
                S_LOAD, S_GAP: begin
                    tmr_n_d = clamp_n(rd_n);
                    wd_d    = '0;
                    state_d = S_RUN;
                end
                S_RUN: begin
                    wd_d = wd_cnt;
                    if (tmr_end_i) begin
                        state_d    = (last_entry && last_pass) ? S_DONE : S_GAP;
                        step_idx_d = last_entry ? '0 : step_idx_q + ADDR_W'(1);
                        pass_d     = (last_entry && !last_pass) ? pass_q + 8'd1 : pass_q;
                    end else if (wd_cnt > wd_lim) begin
                        err_d   = 1'b1;
                        state_d = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
        tmr_start_d = state_d == S_RUN;
        busy_d      = state_d inside {S_LOAD, S_RUN, S_GAP};
        done_d      = state_d == S_DONE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            step_idx_q  <= '0;
            len_q       <= '0;
            pass_q      <= 8'd0;
            loops_q     <= 8'd0;
            wd_q        <= '0;
            tmr_n_q     <= '0;
            tmr_start_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            step_idx_q  <= step_idx_d;
            len_q       <= len_d;
            pass_q      <= pass_d;
            loops_q     <= loops_d;
            wd_q        <= wd_d;
            tmr_n_q     <= tmr_n_d;
            tmr_start_q <= tmr_start_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end
endmodule

// File: tb/tb_timer_sequencer.sv
// tb_timer_sequencer: drives the sequencer against a Timer model; a scoreboard checks every
// Timer period (value, entry, length, gap), every done pulse and every watchdog error.
module tb_timer_sequencer;
    logic        clk = 1'b0, rst_n = 1'b0;
    logic        cfg_we_i = 1'b0, go_i = 1'b0, abort_i = 1'b0, tmr_end_i;
    logic [2:0]  cfg_addr_i = '0;
    logic [15:0] cfg_n_i = '0;
    logic [3:0]  seq_len_i = '0;
    logic [7:0]  loops_i = '0;
    logic [15:0] tmr_n_q;
    logic        tmr_start_q, busy_q, done_q, err_q;
    logic [2:0]  step_idx_q;

    timer_sequencer dut (
        .clk(clk), .rst_n(rst_n), .cfg_we_i(cfg_we_i), .cfg_addr_i(cfg_addr_i),
        .cfg_n_i(cfg_n_i), .seq_len_i(seq_len_i), .loops_i(loops_i), .go_i(go_i),
        .abort_i(abort_i), .tmr_end_i(tmr_end_i), .tmr_n_q(tmr_n_q),
        .tmr_start_q(tmr_start_q), .step_idx_q(step_idx_q), .busy_q(busy_q),
        .done_q(done_q), .err_q(err_q)
    );

    always #5 clk = ~clk;

    // Timer model: start low holds time 0; high counts 0..n-1 then one end cycle.
    logic [15:0] t_time;
    logic        t_end, tie_end = 1'b0;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n || !tmr_start_q) begin
            t_time <= '0;
            t_end  <= 1'b0;
        end else if (t_end) begin
            t_time <= '0;
            t_end  <= 1'b0;
        end else if (t_time == tmr_n_q - 16'd1) begin
            t_time <= '0;
            t_end  <= 1'b1;
        end else begin
            t_time <= t_time + 16'd1;
        end
    end
    assign tmr_end_i = tie_end ? 1'b0 : t_end;

    typedef struct {int kind; int n; int idx; int len;} ev_t;  // kind 0 period, 1 done, 2 error
    ev_t exp_q[$];
    int  tab[8];
    int  n_vec = 0, n_err = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitor
    int  seg_cnt = 0, seg_n = 0, seg_idx = 0, low_cnt = 0;
    bit  in_run = 0, prev_err = 0;
    ev_t e;

    task automatic pop_expect(input int kind);
        if (exp_q.size() == 0) begin
            chk("unexpected_event", kind, -1);
        end else begin
            e = exp_q.pop_front();
            chk("event_kind", kind, e.kind);
        end
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            seg_cnt = 0; low_cnt = 0; in_run = 0; prev_err = 0;
        end else begin
            if (tmr_start_q) begin
                if (seg_cnt == 0) begin
                    seg_n   = int'(tmr_n_q);
                    seg_idx = int'(step_idx_q);
                    if (in_run) chk("gap_len", low_cnt, 1);
                end
                seg_cnt++;
            end else begin
                if (seg_cnt > 0) begin
                    pop_expect(0);
                    if (e.kind == 0) begin
                        chk("period_n", seg_n, e.n);
                        chk("period_idx", seg_idx, e.idx);
                        chk("period_len", seg_cnt, e.len);
                    end
                    in_run  = 1;
                    low_cnt = 0;
                    seg_cnt = 0;
                end
                low_cnt++;
            end
            if (done_q) pop_expect(1);
            if (err_q && !prev_err) pop_expect(2);
            prev_err = err_q;
            if (!busy_q) in_run = 0;
        end
    end

    task automatic wr(input int a, input int v, input bit upd);
        cfg_addr_i = 3'(a);
        cfg_n_i    = 16'(v);
        cfg_we_i   = 1'b1;
        @(negedge clk);
        cfg_we_i = 1'b0;
        if (upd) tab[a] = v;
    endtask

    task automatic expect_run(input int len, input int loops);
        int l = (len > 8) ? 8 : len;
        int p = (loops < 1) ? 1 : loops;
        if (len == 0) return;
        for (int k = 0; k < p; k++)
            for (int i = 0; i < l; i++) begin
                int n = (tab[i] == 0) ? 1 : tab[i];
                exp_q.push_back('{0, n, i, n + 1});
            end
        exp_q.push_back('{1, 0, 0, 0});
    endtask

    task automatic go(input int len, input int loops);
        seq_len_i = 4'(len);
        loops_i   = 8'(loops);
        go_i      = 1'b1;
        @(negedge clk);
        go_i = 1'b0;
    endtask

    task automatic drain(input string name);
        for (int k = 0; k < 3000; k++) begin
            @(negedge clk);
            if (!busy_q && exp_q.size() == 0) break;
        end
        repeat (3) @(negedge clk);
        chk({name, "_pending"}, exp_q.size(), 0);
        chk({name, "_idle"}, int'(busy_q), 0);
        exp_q.delete();
    endtask

    task automatic chk_zero(input string name);
        chk({name, "_n"}, int'(tmr_n_q), 0);
        chk({name, "_start"}, int'(tmr_start_q), 0);
        chk({name, "_idx"}, int'(step_idx_q), 0);
        chk({name, "_busy"}, int'(busy_q), 0);
        chk({name, "_done"}, int'(done_q), 0);
        chk({name, "_err"}, int'(err_q), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 8; i++) tab[i] = 0;
        #12 chk_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // {3,5}, one pass
        wr(0, 3, 1); wr(1, 5, 1);
        expect_run(2, 1); go(2, 1); drain("two_entry");

        // single entry, three passes
        wr(0, 4, 1);
        expect_run(1, 3); go(1, 3); drain("three_pass");

        // abort inside the second entry of {3,5}
        wr(0, 3, 1);
        exp_q.push_back('{0, 3, 0, 4});
        exp_q.push_back('{0, 5, 1, 3});
        go(2, 1);
        for (int k = 0; k < 200; k++) begin
            if (tmr_start_q && step_idx_q == 3'd1) break;
            @(negedge clk);
        end
        repeat (2) @(negedge clk);
        abort_i = 1'b1;
        @(negedge clk);
        abort_i = 1'b0;
        chk("abort_start", int'(tmr_start_q), 0);
        chk("abort_busy", int'(busy_q), 0);
        drain("abort");

        // watchdog: Timer never ends, n=2
        tie_end = 1'b1;
        wr(0, 2, 1);
        exp_q.push_back('{0, 2, 0, 2 + 1 + 4 + 1});
        exp_q.push_back('{2, 0, 0, 0});
        go(1, 1); drain("watchdog");
        chk("err_sticky", int'(err_q), 1);
        tie_end = 1'b0;
        expect_run(1, 1); go(1, 1);
        chk("err_clear", int'(err_q), 0);
        drain("after_err");

        // abort and go together in IDLE
        seq_len_i = 4'd2; loops_i = 8'd1; go_i = 1'b1; abort_i = 1'b1;
        @(negedge clk);
        go_i = 1'b0; abort_i = 1'b0;
        chk("abort_go_busy", int'(busy_q), 0);
        drain("abort_go");

        // zero length go is ignored
        go(0, 1);
        chk("len0_busy", int'(busy_q), 0);
        drain("len0");

        // length 12 runs all 8 entries; a zero entry drives 1
        for (int i = 0; i < 8; i++) wr(i, $urandom_range(1, 6), 1);
        wr(3, 0, 1);
        expect_run(12, 1); go(12, 1); drain("len12");

        // write while busy is ignored
        expect_run(2, 1); go(2, 1);
        wr(1, tab[1] + 3, 0);
        drain("busy_write_run");
        expect_run(2, 1); go(2, 1); drain("busy_write_check");

        // write and go in the same cycle
        tab[0] = tab[0] + 2;
        expect_run(2, 1);
        cfg_we_i = 1'b1; cfg_addr_i = 3'd0; cfg_n_i = 16'(tab[0]);
        seq_len_i = 4'd2; loops_i = 8'd1; go_i = 1'b1;
        @(negedge clk);
        cfg_we_i = 1'b0; go_i = 1'b0;
        drain("write_go");

        // randomized runs
        for (int r = 0; r < 6; r++) begin
            int len, lp;
            for (int i = 0; i < 8; i++) wr(i, $urandom_range(0, 6), 1);
            len = $urandom_range(1, 12);
            lp  = $urandom_range(0, 3);
            expect_run(len, lp); go(len, lp); drain("random");
        end

        // reset in the middle of a run clears outputs and table
        expect_run(8, 2); go(8, 2);
        repeat (15) @(negedge clk);
        #1 rst_n = 1'b0;
        exp_q.delete();
        for (int i = 0; i < 8; i++) tab[i] = 0;
        #1 chk_zero("mid_reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        expect_run(2, 1); go(2, 1); drain("post_reset");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
